mem_arbiter: RTL

Two-requester arbiter and address decoder for the shared data-side resources: data memory and the memory-mapped IO register bank. Requester 0 is the processor MEM stage; requester 1 is a secondary master, such as a program loader or DMA. The block grants one requester at a time and decodes its address to a data-memory or IO strobe. It returns read data, or an error for unmapped addresses, with a one-cycle acknowledge.

---
 rtl/mem_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter and data-memory / IO-register decoder, 2-cycle req-to-ack.
// Build option: define MEM_ARB_RR_EN for round-robin grant; default is fixed priority to requester 0.
module mem_arbiter #(
   parameter int WIDTH     = 32,
   parameter int DATA_SIZE = 256,
   parameter int IO_BASE   = 256,
   parameter int IO_SIZE   = 1,
   localparam int MAW      = $clog2(DATA_SIZE),
   localparam int IAW      = (IO_SIZE > 1) ? $clog2(IO_SIZE) : 1
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic [1:0]               req,
   input  logic [1:0]               we,
   input  logic [2*WIDTH-1:0]       addr,
   input  logic [2*WIDTH-1:0]       wdata,
   input  logic [5:0]               len,
   output logic [1:0]               ack,
   output logic [WIDTH-1:0]         rdata,
   output logic                     err,
   output logic [1:0]               gnt,
   output logic [MAW-1:0]           mem_addr,
   output logic [WIDTH-1:0]         mem_in,
   output logic [2:0]               mem_len,
   output logic                     mem_read,
   output logic                     mem_write,
   output logic                     mem_ce,
   input  logic [WIDTH-1:0]         mem_out,
   output logic [IAW-1:0]           io_addr,
   output logic [WIDTH-1:0]         io_data_in,
   output logic                     io_w_en,
   input  logic [IO_SIZE*WIDTH-1:0] io_data_out
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;
   typedef enum logic [1:0] {R_NONE, R_DATA, R_IO} region_e;

   // One extra bit so region bounds never wrap at the top of the address space.
   localparam logic [WIDTH:0] DATA_END = (WIDTH+1)'(DATA_SIZE);
   localparam logic [WIDTH:0] IO_LO    = (WIDTH+1)'(IO_BASE);
   localparam logic [WIDTH:0] IO_HI    = (WIDTH+1)'(IO_BASE + 4*IO_SIZE);

   state_e           state_q, state_d;
   region_e          region_q, region_d;
   logic             win_q, win_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             err_q, err_d;
`ifdef MEM_ARB_RR_EN
   logic             ptr_q, ptr_d;
`endif

   logic             win_sel;
   logic [WIDTH-1:0] sel_addr;
   logic [WIDTH-1:0] w_addr, w_wdata;
   logic             w_we;
   logic [2:0]       w_len;
   logic [IAW-1:0]   io_idx;
   logic [WIDTH-1:0] io_word;

   function automatic region_e decode(input logic [WIDTH-1:0] a);
      logic [WIDTH:0] ax;
      ax = {1'b0, a};
      if (ax < DATA_END) return R_DATA;
      if (ax >= IO_LO && ax < IO_HI) return R_IO;
      return R_NONE;
   endfunction

   always_comb begin
`ifdef MEM_ARB_RR_EN
      win_sel = (req == 2'b11) ? ptr_q : req[1];
`else
      win_sel = ~req[0];
`endif
      sel_addr = win_sel ? addr[2*WIDTH-1:WIDTH] : addr[WIDTH-1:0];
      w_addr   = win_q ? addr[2*WIDTH-1:WIDTH]  : addr[WIDTH-1:0];
      w_wdata  = win_q ? wdata[2*WIDTH-1:WIDTH] : wdata[WIDTH-1:0];
      w_we     = win_q ? we[1] : we[0];
      w_len    = win_q ? len[5:3] : len[2:0];
      io_idx   = IAW'((w_addr - WIDTH'(IO_BASE)) >> 2);
   end

   always_comb begin
      io_word = '0;
      for (int i = 0; i < IO_SIZE; i++)
         if (io_idx == IAW'(i)) io_word = io_data_out[i*WIDTH +: WIDTH];
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= S_IDLE;
         region_q <= R_NONE;
         win_q    <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
         ptr_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         region_q <= region_d;
         win_q    <= win_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
`ifdef MEM_ARB_RR_EN
         ptr_q    <= ptr_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      region_d = region_q;
      win_d    = win_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
`ifdef MEM_ARB_RR_EN
      ptr_d    = ptr_q;
`endif
      case (state_q)
         S_IDLE: if (|req) begin
            win_d    = win_sel;
            region_d = decode(sel_addr);
            state_d  = S_ACCESS;
`ifdef MEM_ARB_RR_EN
            ptr_d    = ~win_sel;
`endif
         end
         S_ACCESS: begin
            state_d = S_RESP;
            err_d   = (region_q == R_NONE);
            rdata_d = '0;
            if (!w_we) begin
               if (region_q == R_DATA) rdata_d = mem_out;
               else if (region_q == R_IO) rdata_d = io_word;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      gnt        = '0;
      ack        = '0;
      mem_addr   = '0;
      mem_in     = '0;
      mem_len    = '0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_ce     = 1'b0;
      io_addr    = '0;
      io_data_in = '0;
      io_w_en    = 1'b0;
      rdata      = rdata_q;
      err        = err_q;
      // Datapath shows the latched winner for the whole transaction; strobes only in ACCESS.
      if (state_q != S_IDLE) begin
         mem_addr   = w_addr[MAW-1:0];
         mem_in     = w_wdata;
         mem_len    = w_len;
         io_addr    = io_idx;
         io_data_in = w_wdata;
      end
      if (state_q == S_ACCESS) begin
         gnt[win_q] = 1'b1;
         if (region_q == R_DATA) begin
            mem_ce    = 1'b1;
            mem_read  = ~w_we;
            mem_write = w_we;
         end else if (region_q == R_IO) begin
            io_w_en   = w_we;
         end
      end
      if (state_q == S_RESP) ack[win_q] = 1'b1;
   end

endmodule
